// File: rtl/track_pkg.sv
// Shared types and constants for the face-tracking frame sequencer.
// Holds the state enum, the frame-size defaults and the search half-window derivation.
package track_pkg;

    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;
    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        SCAN,
        UPDATE
    } track_state_e;

    // Half of the search window side: the search margin plus half a template.
    function automatic int half_win(input int search_radius, input int template_width);
        return search_radius + template_width / 2;
    endfunction

endpackage

// File: rtl/track_sequencer_if.sv
// Correlator handshake between the sequencer (master) and the correlator (slave).
// The sequencer launches a scan and receives the best-match top-left corner.
interface track_sequencer_if;
    import track_pkg::*;

    logic               corr_start;
    logic               corr_done;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;

    modport master (output corr_start, input corr_done, max_x, max_y);
    modport slave  (input corr_start, output corr_done, max_x, max_y);

endinterface

// File: rtl/win_clamp.sv
// One axis of the search window: clamps a candidate centre into the frame and
// derives the inclusive window bounds from the currently committed centre.
module win_clamp
    import track_pkg::*;
#(
    parameter int LIMIT    = FRAME_W,
    parameter int HALF_WIN = 48
) (
    input  logic [11:0]        center_in,
    input  logic [COORD_W-1:0] center_cur,
    output logic [COORD_W-1:0] center_clamped,
    output logic [COORD_W-1:0] bound_lo,
    output logic [COORD_W-1:0] bound_hi
);

    localparam logic [11:0]        MIN_C    = 12'(HALF_WIN);
    localparam logic [11:0]        MAX_C    = 12'(LIMIT - HALF_WIN);
    localparam logic [COORD_W-1:0] MIN_C10  = COORD_W'(HALF_WIN);
    localparam logic [COORD_W-1:0] MAX_C10  = COORD_W'(LIMIT - HALF_WIN);
    localparam logic [COORD_W-1:0] HW_LO    = COORD_W'(HALF_WIN);
    localparam logic [COORD_W-1:0] HW_HI    = COORD_W'(HALF_WIN - 1);

    // NOTE: every branch assigns the output, so no latch is inferred.
    always_comb begin
        if (center_in < MIN_C)
            center_clamped = MIN_C10;
        else if (center_in > MAX_C)
            center_clamped = MAX_C10;
        else
            center_clamped = center_in[COORD_W-1:0];
    end

    assign bound_lo = center_cur - HW_LO;
    assign bound_hi = center_cur + HW_HI;

endmodule

// File: rtl/track_sequencer.sv
// Frame-level tracking controller: freeze a frame, scan it, recentre the window.
// Optional rounded-average smoothing of the new centre: define TRACK_SMOOTH_EN.
module track_sequencer
    import track_pkg::*;
#(
    parameter int VGA_WIDTH      = FRAME_W,
    parameter int VGA_HEIGHT     = FRAME_H,
    parameter int TEMPLATE_WIDTH = 32,
    parameter int SEARCH_RADIUS  = 32,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tracking_en,
    input  logic [COORD_W-1:0]       init_x,
    input  logic [COORD_W-1:0]       init_y,
    input  logic                     frame_end,
    track_sequencer_if.master        corr,
    output logic                     static_we,
    output logic [COORD_W-1:0]       c_x,
    output logic [COORD_W-1:0]       c_y,
    output logic [COORD_W-1:0]       left,
    output logic [COORD_W-1:0]       right,
    output logic [COORD_W-1:0]       top,
    output logic [COORD_W-1:0]       bottom,
    output logic                     track_update,
    output logic                     lost
);

    localparam int                 HALF_WIN = half_win(SEARCH_RADIUS, TEMPLATE_WIDTH);
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]        HALF_TPL = 12'(TEMPLATE_WIDTH / 2);
    localparam logic [COORD_W-1:0] RST_CX   = COORD_W'(VGA_WIDTH / 2);
    localparam logic [COORD_W-1:0] RST_CY   = COORD_W'(VGA_HEIGHT / 2);

    track_state_e       state, state_nxt;
    logic [CNT_W-1:0]   scan_cnt;
    logic               timeout_hit;
    logic [COORD_W-1:0] max_x_q, max_y_q;
    logic [11:0]        meas_x, meas_y, upd_x, upd_y, target_x, target_y;
    logic [COORD_W-1:0] clamp_x, clamp_y, lo_x, hi_x, lo_y, hi_y;
    logic               static_we_nxt, corr_start_nxt, track_update_nxt, lost_nxt;
    logic               load_centre;

    assign timeout_hit = (scan_cnt == CNT_LAST);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; dropping tracking_en wins over any handshake.
    always_comb begin
        state_nxt = state;
        if (!tracking_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARM;
                ARM:     if (frame_end) state_nxt = CAPTURE;
                CAPTURE: if (frame_end) state_nxt = SCAN;
                SCAN: begin
                    if (corr.corr_done)   state_nxt = UPDATE;
                    else if (timeout_hit) state_nxt = ARM;
                end
                UPDATE:  state_nxt = ARM;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: next values for the registered outputs.
    always_comb begin
        static_we_nxt    = (state_nxt == CAPTURE);
        corr_start_nxt   = (state == CAPTURE) && (state_nxt == SCAN);
        track_update_nxt = (state == UPDATE) && (state_nxt == ARM);
        load_centre      = (state == IDLE || state == UPDATE) && (state_nxt == ARM);
        lost_nxt         = lost;
        if (load_centre)
            lost_nxt = 1'b0;
        else if (state == SCAN && state_nxt == ARM)
            lost_nxt = 1'b1;
    end

    assign meas_x = {2'b00, max_x_q} + HALF_TPL;
    assign meas_y = {2'b00, max_y_q} + HALF_TPL;

`ifdef TRACK_SMOOTH_EN
    logic [12:0] sum_x, sum_y;
    assign sum_x = {3'b000, c_x} + {1'b0, meas_x} + 13'd1;
    assign sum_y = {3'b000, c_y} + {1'b0, meas_y} + 13'd1;
    assign upd_x = 12'(sum_x >> 1);
    assign upd_y = 12'(sum_y >> 1);
`else
    assign upd_x = meas_x;
    assign upd_y = meas_y;
`endif

    // The single clamp per axis serves both the user init and the measured centre.
    assign target_x = (state == IDLE) ? {2'b00, init_x} : upd_x;
    assign target_y = (state == IDLE) ? {2'b00, init_y} : upd_y;

    win_clamp #(.LIMIT(VGA_WIDTH), .HALF_WIN(HALF_WIN)) u_clamp_x (
        .center_in      (target_x),
        .center_cur     (c_x),
        .center_clamped (clamp_x),
        .bound_lo       (lo_x),
        .bound_hi       (hi_x)
    );

    win_clamp #(.LIMIT(VGA_HEIGHT), .HALF_WIN(HALF_WIN)) u_clamp_y (
        .center_in      (target_y),
        .center_cur     (c_y),
        .center_clamped (clamp_y),
        .bound_lo       (lo_y),
        .bound_hi       (hi_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            static_we       <= 1'b0;
            corr.corr_start <= 1'b0;
            track_update    <= 1'b0;
            lost            <= 1'b0;
            scan_cnt        <= '0;
            max_x_q         <= '0;
            max_y_q         <= '0;
            c_x             <= RST_CX;
            c_y             <= RST_CY;
            left            <= RST_CX - COORD_W'(HALF_WIN);
            right           <= RST_CX + COORD_W'(HALF_WIN - 1);
            top             <= RST_CY - COORD_W'(HALF_WIN);
            bottom          <= RST_CY + COORD_W'(HALF_WIN - 1);
        end else begin
            static_we       <= static_we_nxt;
            corr.corr_start <= corr_start_nxt;
            track_update    <= track_update_nxt;
            lost            <= lost_nxt;
            if (state != SCAN)
                scan_cnt <= '0;
            else
                scan_cnt <= scan_cnt + 1'b1;
            if (state == SCAN && corr.corr_done) begin
                max_x_q <= corr.max_x;
                max_y_q <= corr.max_y;
            end
            if (load_centre) begin
                c_x <= clamp_x;
                c_y <= clamp_y;
            end
            // Bounds trail the centre by one cycle.
            left   <= lo_x;
            right  <= hi_x;
            top    <= lo_y;
            bottom <= hi_y;
        end
    end

endmodule

// File: tb/tb_track_sequencer.sv
// Directed bench for track_sequencer: capture/scan flow, clamping, timeout,
// enable override and asynchronous reset, with hand-computed expectations.
module tb_track_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       tracking_en;
    logic [9:0] init_x, init_y;
    logic       frame_end;
    logic       static_we, track_update, lost;
    logic [9:0] c_x, c_y, left, right, top, bottom;
    int         total = 0;
    int         bad   = 0;
    int         we_cycles;

`ifdef TRACK_SMOOTH_EN
    localparam logic [9:0] U1_X = 218, U1_Y = 153, U1_L = 170, U1_R = 265, U1_T = 105, U1_B = 200;
    localparam logic [9:0] U2_X = 432, U2_Y = 320, U2_R = 479, U2_B = 367;
    localparam logic [9:0] U3_X = 324, U3_Y = 268;
    localparam logic [9:0] U4_X = 250;
`else
    localparam logic [9:0] U1_X = 116, U1_Y = 66, U1_L = 68, U1_R = 163, U1_T = 18, U1_B = 113;
    localparam logic [9:0] U2_X = 592, U2_Y = 432, U2_R = 639, U2_B = 479;
    localparam logic [9:0] U3_X = 216, U3_Y = 216;
    localparam logic [9:0] U4_X = 300;
`endif

    track_sequencer_if corr_if ();

    track_sequencer #(.TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .tracking_en  (tracking_en),
        .init_x       (init_x),
        .init_y       (init_y),
        .frame_end    (frame_end),
        .corr         (corr_if),
        .static_we    (static_we),
        .c_x          (c_x),
        .c_y          (c_y),
        .left         (left),
        .right        (right),
        .top          (top),
        .bottom       (bottom),
        .track_update (track_update),
        .lost         (lost)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From ARM: one frame_end to start capturing, a short frame, then frame_end to scan.
    task automatic run_to_scan();
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("arm_to_capture_we", {9'd0, static_we}, 10'd1);
        tick(3);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("scan_corr_start", {9'd0, corr_if.corr_start}, 10'd1);
        check("scan_we_low", {9'd0, static_we}, 10'd0);
    endtask

    task automatic do_update(input logic [9:0] mx, input logic [9:0] my);
        corr_if.corr_done = 1'b1; corr_if.max_x = mx; corr_if.max_y = my;
        tick();
        corr_if.corr_done = 1'b0;
        check("update_cycle_no_pulse", {9'd0, track_update}, 10'd0);
        tick();
        check("track_update_pulse", {9'd0, track_update}, 10'd1);
    endtask

    initial begin
        reset = 1'b1; tracking_en = 1'b0; init_x = '0; init_y = '0; frame_end = 1'b0;
        corr_if.corr_done = 1'b0; corr_if.max_x = '0; corr_if.max_y = '0;
        #1;
        check("async_reset_cx", c_x, 10'd320);
        tick(2);
        reset = 1'b0;
        tick();
        check("rst_we", {9'd0, static_we}, 10'd0);
        check("rst_start", {9'd0, corr_if.corr_start}, 10'd0);
        check("rst_upd", {9'd0, track_update}, 10'd0);
        check("rst_lost", {9'd0, lost}, 10'd0);
        check("rst_cx", c_x, 10'd320);
        check("rst_cy", c_y, 10'd240);
        check("rst_left", left, 10'd272);
        check("rst_right", right, 10'd367);
        check("rst_top", top, 10'd192);
        check("rst_bottom", bottom, 10'd287);

        // Enable with the frame centre, then capture exactly one 10-cycle frame.
        init_x = 10'd320; init_y = 10'd240; tracking_en = 1'b1;
        tick();
        check("arm_we_low", {9'd0, static_we}, 10'd0);
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        we_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (static_we) we_cycles++;
            if (i == 9) frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        check("we_frame_len", 10'(we_cycles), 10'd10);
        check("capture_end_we", {9'd0, static_we}, 10'd0);
        check("corr_start_high", {9'd0, corr_if.corr_start}, 10'd1);
        tick();
        check("corr_start_one_cycle", {9'd0, corr_if.corr_start}, 10'd0);

        // First match, well inside the frame.
        tick(2);
        do_update(10'd100, 10'd50);
        check("u1_cx", c_x, U1_X);
        check("u1_cy", c_y, U1_Y);
        check("u1_bounds_lag", left, 10'd272);
        tick();
        check("u1_pulse_once", {9'd0, track_update}, 10'd0);
        check("u1_left", left, U1_L);
        check("u1_right", right, U1_R);
        check("u1_top", top, U1_T);
        check("u1_bottom", bottom, U1_B);

        // corr_done outside SCAN must be ignored.
        corr_if.corr_done = 1'b1; corr_if.max_x = 10'd0; corr_if.max_y = 10'd0;
        tick(); corr_if.corr_done = 1'b0;
        tick();
        check("stray_done_no_upd", {9'd0, track_update}, 10'd0);
        check("stray_done_cx", c_x, U1_X);

        // Match near the far corner: centre clamps so the window stays in frame.
        run_to_scan();
        do_update(10'd630, 10'd470);
        check("u2_cx", c_x, U2_X);
        check("u2_cy", c_y, U2_Y);
        tick();
        check("u2_right", right, U2_R);
        check("u2_bottom", bottom, U2_B);

        // Timeout: 100 cycles in SCAN, with a frame_end in the middle that must be ignored.
        run_to_scan();
        for (int i = 0; i < 99; i++) begin
            if (i == 50) frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
        end
        check("timeout_not_yet", {9'd0, lost}, 10'd0);
        tick();
        check("timeout_lost", {9'd0, lost}, 10'd1);
        check("timeout_no_upd", {9'd0, track_update}, 10'd0);
        check("timeout_cx_kept", c_x, U2_X);
        check("timeout_cy_kept", c_y, U2_Y);
        run_to_scan();
        check("lost_held_in_scan", {9'd0, lost}, 10'd1);
        do_update(10'd200, 10'd200);
        check("u3_lost_cleared", {9'd0, lost}, 10'd0);
        check("u3_cx", c_x, U3_X);
        check("u3_cy", c_y, U3_Y);

        // Enable dropped in CAPTURE together with frame_end: back to IDLE, no launch.
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("drop_capture_we", {9'd0, static_we}, 10'd1);
        tick(2);
        tracking_en = 1'b0; frame_end = 1'b1;
        tick(); frame_end = 1'b0;
        check("drop_we_low", {9'd0, static_we}, 10'd0);
        check("drop_no_start", {9'd0, corr_if.corr_start}, 10'd0);
        tick();
        check("drop_no_start_later", {9'd0, corr_if.corr_start}, 10'd0);

        // Re-enable with an out-of-range box: the init centre is clamped too.
        init_x = 10'd10; init_y = 10'd470; tracking_en = 1'b1;
        tick();
        check("init_clamp_cx", c_x, 10'd48);
        check("init_clamp_cy", c_y, 10'd432);
        tick();
        check("init_clamp_left", left, 10'd0);
        check("init_clamp_right", right, 10'd95);
        check("init_clamp_top", top, 10'd384);
        check("init_clamp_bottom", bottom, 10'd479);

        // Old centre 200, measured 300.
        tracking_en = 1'b0; tick();
        init_x = 10'd200; init_y = 10'd240; tracking_en = 1'b1;
        tick();
        check("u4_init_cx", c_x, 10'd200);
        run_to_scan();
        tick();
        do_update(10'd284, 10'd224);
        check("u4_cx", c_x, U4_X);
        check("u4_cy", c_y, 10'd240);

        // Reset mid-CAPTURE takes effect between clock edges.
        frame_end = 1'b1; tick(); frame_end = 1'b0;
        check("pre_reset_we", {9'd0, static_we}, 10'd1);
        #3 reset = 1'b1;
        #1;
        check("async_rst_we", {9'd0, static_we}, 10'd0);
        check("async_rst_cx", c_x, 10'd320);
        check("async_rst_cy", c_y, 10'd240);
        check("async_rst_left", left, 10'd272);
        check("async_rst_bottom", bottom, 10'd287);
        check("async_rst_lost", {9'd0, lost}, 10'd0);
        #2 reset = 1'b0;
        tick();
        check("post_reset_we", {9'd0, static_we}, 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
